// File: rtl/eth_frame_builder.sv
// eth_frame_builder
//   Transmit-side Ethernet frame assembler. Takes one metadata record (dst MAC,
//   src MAC, EtherType) and a byte-wide AXI-S payload, and emits a byte-wide
//   AXI-S frame: 14-byte header, the payload passed through with zero latency,
//   then optional zero padding up to MIN_FRAME_BYTES (FCS excluded).
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   meta_valid/meta_ready            metadata handshake (ready only in IDLE)
//   meta_dst_mac/src_mac/ethertype   header fields, most significant byte sent first
//   s_tdata/s_tvalid/s_tready/s_tlast  payload stream in
//   m_tdata/m_tvalid/m_tready/m_tlast  frame stream out
//   frame_start                      pulse on transfer of header byte 0
//   header_done                      pulse on transfer of header byte 13
//   frame_end                        pulse on transfer with m_tlast=1
//   frames_sent                      completed frame count, wraps
module eth_frame_builder #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter bit          PAD_EN          = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  meta_valid,
  output logic                  meta_ready,
  input  logic [47:0]           meta_dst_mac,
  input  logic [47:0]           meta_src_mac,
  input  logic [15:0]           meta_ethertype,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  frame_start,
  output logic                  header_done,
  output logic                  frame_end,
  output logic [31:0]           frames_sent
);

  if (DATA_WIDTH != 8) begin : g_chk_width
    $fatal(1, "eth_frame_builder: only DATA_WIDTH=8 is supported");
  end
  if (MIN_FRAME_BYTES < 15) begin : g_chk_min
    $fatal(1, "eth_frame_builder: MIN_FRAME_BYTES must be >= 15");
  end

  typedef enum logic [1:0] {StIdle, StHdr, StPay, StPad} state_e;

  state_e      state_q;
  logic [3:0]  hdr_idx_q;
  logic [15:0] len_q;
  logic [47:0] dst_q;
  logic [47:0] src_q;
  logic [15:0] type_q;
  logic [31:0] frames_sent_q;

  logic [7:0]  hdr_byte;
  logic [15:0] len_next;
  logic        pad_needed;
  logic        pad_last;
  logic        m_xfer;

  // Saturating length; only used to decide padding, never to cut a frame.
  assign len_next   = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
  // Would the frame still be short once the current payload byte is counted?
  assign pad_needed = PAD_EN && (({1'b0, len_q} + 17'd1) < 17'(MIN_FRAME_BYTES));
  assign pad_last   = (32'(len_q) == (MIN_FRAME_BYTES - 32'd1));

  always_comb begin
    hdr_byte = 8'h00;
    unique case (hdr_idx_q)
      4'd0:    hdr_byte = dst_q[47:40];
      4'd1:    hdr_byte = dst_q[39:32];
      4'd2:    hdr_byte = dst_q[31:24];
      4'd3:    hdr_byte = dst_q[23:16];
      4'd4:    hdr_byte = dst_q[15:8];
      4'd5:    hdr_byte = dst_q[7:0];
      4'd6:    hdr_byte = src_q[47:40];
      4'd7:    hdr_byte = src_q[39:32];
      4'd8:    hdr_byte = src_q[31:24];
      4'd9:    hdr_byte = src_q[23:16];
      4'd10:   hdr_byte = src_q[15:8];
      4'd11:   hdr_byte = src_q[7:0];
      4'd12:   hdr_byte = type_q[15:8];
      4'd13:   hdr_byte = type_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // Stream outputs decode from state; PAY is a zero-latency pass-through.
  always_comb begin
    meta_ready = 1'b0;
    m_tvalid   = 1'b0;
    m_tdata    = '0;
    m_tlast    = 1'b0;
    s_tready   = 1'b0;
    unique case (state_q)
      StIdle: meta_ready = 1'b1;
      StHdr: begin
        m_tvalid = 1'b1;
        m_tdata  = hdr_byte;
      end
      StPay: begin
        m_tvalid = s_tvalid;
        m_tdata  = s_tdata;
        s_tready = m_tready;
        m_tlast  = s_tlast && !pad_needed;
      end
      StPad: begin
        m_tvalid = 1'b1;
        m_tlast  = pad_last;
      end
      default: meta_ready = 1'b0;
    endcase
  end

  assign m_xfer      = m_tvalid && m_tready;
  assign frame_start = m_xfer && (state_q == StHdr) && (hdr_idx_q == 4'd0);
  assign header_done = m_xfer && (state_q == StHdr) && (hdr_idx_q == 4'd13);
  assign frame_end   = m_xfer && m_tlast;
  assign frames_sent = frames_sent_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      hdr_idx_q     <= 4'd0;
      len_q         <= 16'd0;
      dst_q         <= 48'd0;
      src_q         <= 48'd0;
      type_q        <= 16'd0;
      frames_sent_q <= 32'd0;
    end else begin
      if (frame_end) begin
        frames_sent_q <= frames_sent_q + 32'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (meta_valid) begin
            dst_q     <= meta_dst_mac;
            src_q     <= meta_src_mac;
            type_q    <= meta_ethertype;
            hdr_idx_q <= 4'd0;
            len_q     <= 16'd0;
            state_q   <= StHdr;
          end
        end
        StHdr: begin
          if (m_tready) begin
            hdr_idx_q <= hdr_idx_q + 4'd1;
            len_q     <= len_next;
            if (hdr_idx_q == 4'd13) begin
              state_q <= StPay;
            end
          end
        end
        StPay: begin
          if (s_tvalid && m_tready) begin
            len_q <= len_next;
            if (s_tlast) begin
              state_q <= pad_needed ? StPad : StIdle;
            end
          end
        end
        StPad: begin
          if (m_tready) begin
            len_q <= len_next;
            if (pad_last) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_builder.sv
// Directed bench for eth_frame_builder: a padded instance (PAD_EN=1) and an
// unpadded instance (PAD_EN=0) share one stimulus driver selected by 'sel'.
module tb_eth_frame_builder;

  localparam logic [47:0] Dst1 = 48'h001122334455;
  localparam logic [47:0] Src1 = 48'h66778899AABB;
  localparam logic [15:0] Typ1 = 16'h0800;
  localparam logic [47:0] Dst2 = 48'hA1A2A3A4A5A6;
  localparam logic [47:0] Src2 = 48'hB1B2B3B4B5B6;
  localparam logic [15:0] Typ2 = 16'h86DD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        rand_mode = 1'b0;
  logic        meta_valid = 1'b0;
  logic [47:0] meta_dst = '0;
  logic [47:0] meta_src = '0;
  logic [15:0] meta_type = '0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        m_tready = 1'b1;

  logic        meta_ready_p, s_tready_p, m_tvalid_p, m_tlast_p, fs_p, hd_p, fe_p;
  logic        meta_ready_n, s_tready_n, m_tvalid_n, m_tlast_n, fs_n, hd_n, fe_n;
  logic [7:0]  m_tdata_p, m_tdata_n;
  logic [31:0] frames_p, frames_n;

  eth_frame_builder #(.DATA_WIDTH(8), .MIN_FRAME_BYTES(60), .PAD_EN(1'b1)) u_dut_pad (
    .clk(clk), .rst_n(rst_n),
    .meta_valid(meta_valid && !sel), .meta_ready(meta_ready_p),
    .meta_dst_mac(meta_dst), .meta_src_mac(meta_src), .meta_ethertype(meta_type),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid && !sel), .s_tready(s_tready_p), .s_tlast(s_tlast),
    .m_tdata(m_tdata_p), .m_tvalid(m_tvalid_p), .m_tready(sel ? 1'b1 : m_tready),
    .m_tlast(m_tlast_p), .frame_start(fs_p), .header_done(hd_p), .frame_end(fe_p),
    .frames_sent(frames_p)
  );

  eth_frame_builder #(.DATA_WIDTH(8), .MIN_FRAME_BYTES(60), .PAD_EN(1'b0)) u_dut_nopad (
    .clk(clk), .rst_n(rst_n),
    .meta_valid(meta_valid && sel), .meta_ready(meta_ready_n),
    .meta_dst_mac(meta_dst), .meta_src_mac(meta_src), .meta_ethertype(meta_type),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid && sel), .s_tready(s_tready_n), .s_tlast(s_tlast),
    .m_tdata(m_tdata_n), .m_tvalid(m_tvalid_n), .m_tready(sel ? m_tready : 1'b1),
    .m_tlast(m_tlast_n), .frame_start(fs_n), .header_done(hd_n), .frame_end(fe_n),
    .frames_sent(frames_n)
  );

  wire        meta_ready  = sel ? meta_ready_n : meta_ready_p;
  wire        s_tready    = sel ? s_tready_n : s_tready_p;
  wire        m_tvalid    = sel ? m_tvalid_n : m_tvalid_p;
  wire        m_tlast     = sel ? m_tlast_n : m_tlast_p;
  wire [7:0]  m_tdata     = sel ? m_tdata_n : m_tdata_p;
  wire        frame_start = sel ? fs_n : fs_p;
  wire        header_done = sel ? hd_n : hd_p;
  wire        frame_end   = sel ? fe_n : fe_p;
  wire [31:0] frames_sent = sel ? frames_n : frames_p;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic to_flag = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1 m_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: entries are {s_tready, m_tlast, m_tdata} per output transfer.
  logic [9:0] q[$];
  int fs_cnt, hd_cnt, fe_cnt, stall_cnt, stab_err, fs_cyc;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic prev_last;

  always @(negedge clk) begin
    if (m_tvalid && m_tready) q.push_back({s_tready, m_tlast, m_tdata});
    if (frame_start) begin
      fs_cnt = fs_cnt + 1;
      fs_cyc = cyc;
    end
    if (header_done) hd_cnt = hd_cnt + 1;
    if (frame_end) fe_cnt = fe_cnt + 1;
    if (prev_stall && m_tvalid && (m_tdata !== prev_data || m_tlast !== prev_last))
      stab_err = stab_err + 1;
    prev_stall = m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    if (prev_stall) stall_cnt = stall_cnt + 1;
  end

  task automatic clear_mon();
    q.delete();
    fs_cnt = 0; hd_cnt = 0; fe_cnt = 0; stall_cnt = 0; stab_err = 0; fs_cyc = -1;
    to_flag = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_meta(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                           output int hs);
    logic got = 1'b0;
    hs = -1;
    meta_dst = d; meta_src = s; meta_type = t; meta_valid = 1'b1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (meta_ready) begin
        got = 1'b1;
        hs = cyc;
      end
    end
    if (!got) to_flag = 1'b1;
    @(posedge clk);
    #1 meta_valid = 1'b0;
  endtask

  task automatic send_payload(input int n, input logic [7:0] start);
    for (int i = 0; i < n; i++) begin
      logic got = 1'b0;
      s_tdata = 8'(start + 8'(i)); s_tvalid = 1'b1; s_tlast = (i == n - 1);
      for (int k = 0; k < 500 && !got; k++) begin
        @(negedge clk);
        if (s_tready) got = 1'b1;
      end
      if (!got) to_flag = 1'b1;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic wait_end(input int target);
    for (int k = 0; k < 600 && fe_cnt < target; k++) @(negedge clk);
    if (fe_cnt < target) to_flag = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input int i, input int n, input logic [7:0] start,
                                          input logic [47:0] d, input logic [47:0] s,
                                          input logic [15:0] t);
    logic [111:0] h;
    h = {d, s, t} << (8 * i);
    if (i < 14) return h[111:104];
    if (i < 14 + n) return 8'(start + 8'(i - 14));
    return 8'h00;
  endfunction

  // Number of bad bytes (data or tlast) in the frame starting at q[off].
  function automatic int frame_errs(input int off, input int n, input logic [7:0] start,
                                    input int pad_len, input logic [47:0] d,
                                    input logic [47:0] s, input logic [15:0] t);
    int explen = (14 + n > pad_len) ? 14 + n : pad_len;
    int errs = 0;
    for (int i = 0; i < explen; i++) begin
      if (off + i >= q.size()) errs++;
      else if (q[off+i][7:0] !== exp_byte(i, n, start, d, s, t) ||
               q[off+i][8] !== (i == explen - 1)) errs++;
    end
    return errs;
  endfunction

  task automatic test_reset();
    #12;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
    n_cmp++; if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast got %b want 0", m_tlast); end
    n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("FAIL reset_s_tready got %b want 0", s_tready); end
    n_cmp++; if (m_tdata !== 8'h00) begin n_bad++; $display("FAIL reset_tdata got %h want 00", m_tdata); end
    n_cmp++; if (meta_ready !== 1'b1) begin n_bad++; $display("FAIL reset_meta_ready got %b want 1", meta_ready); end
    n_cmp++; if (frames_sent !== 32'd0) begin n_bad++; $display("FAIL reset_frames got %0d want 0", frames_sent); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    int hs, e;
    clear_mon();
    fork
      send_meta(Dst1, Src1, Typ1, hs);
      send_payload(46, 8'h01);
    join
    wait_end(1);
    e = frame_errs(0, 46, 8'h01, 60, Dst1, Src1, Typ1);
    n_cmp++; if (to_flag !== 1'b0) begin n_bad++; $display("FAIL t1_timeout got %b want 0", to_flag); end
    n_cmp++; if (q.size() !== 60) begin n_bad++; $display("FAIL t1_len got %0d want 60", q.size()); end
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL t1_bytes bad=%0d want 0", e); end
    n_cmp++; if (frames_sent !== 32'd1) begin n_bad++; $display("FAIL t1_frames got %0d want 1", frames_sent); end
    n_cmp++; if (fs_cnt !== 1 || hd_cnt !== 1 || fe_cnt !== 1) begin
      n_bad++; $display("FAIL t1_pulses got %0d/%0d/%0d want 1/1/1", fs_cnt, hd_cnt, fe_cnt);
    end
  endtask

  task automatic test_pad();
    int hs, e, pad_rdy, pay_rdy;
    clear_mon();
    fork
      send_meta(Dst1, Src1, Typ1, hs);
      send_payload(10, 8'h01);
    join
    wait_end(1);
    e = frame_errs(0, 10, 8'h01, 60, Dst1, Src1, Typ1);
    pad_rdy = 0; pay_rdy = 0;
    for (int i = 14; i < q.size(); i++) begin
      if (i < 24 && q[i][9]) pay_rdy++;
      if (i >= 24 && q[i][9]) pad_rdy++;
    end
    n_cmp++; if (to_flag !== 1'b0) begin n_bad++; $display("FAIL t2_timeout got %b want 0", to_flag); end
    n_cmp++; if (q.size() !== 60) begin n_bad++; $display("FAIL t2_len got %0d want 60", q.size()); end
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL t2_bytes bad=%0d want 0", e); end
    n_cmp++; if (pad_rdy !== 0) begin n_bad++; $display("FAIL t2_pad_s_tready got %0d want 0", pad_rdy); end
    n_cmp++; if (pay_rdy !== 10) begin n_bad++; $display("FAIL t2_pay_s_tready got %0d want 10", pay_rdy); end
    n_cmp++; if (fe_cnt !== 1) begin n_bad++; $display("FAIL t2_frame_end got %0d want 1", fe_cnt); end
    n_cmp++; if (frames_sent !== 32'd2) begin n_bad++; $display("FAIL t2_frames got %0d want 2", frames_sent); end
  endtask

  task automatic test_no_pad();
    int hs, e;
    sel = 1'b1;
    clear_mon();
    fork
      send_meta(Dst1, Src1, Typ1, hs);
      send_payload(10, 8'h01);
    join
    wait_end(1);
    e = frame_errs(0, 10, 8'h01, 0, Dst1, Src1, Typ1);
    n_cmp++; if (to_flag !== 1'b0) begin n_bad++; $display("FAIL t3_timeout got %b want 0", to_flag); end
    n_cmp++; if (q.size() !== 24) begin n_bad++; $display("FAIL t3_len got %0d want 24", q.size()); end
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL t3_bytes bad=%0d want 0", e); end
    n_cmp++; if (frames_sent !== 32'd1) begin n_bad++; $display("FAIL t3_frames got %0d want 1", frames_sent); end
    sel = 1'b0;
  endtask

  task automatic test_random_ready();
    int hs, e;
    rand_mode = 1'b1;
    clear_mon();
    fork
      send_meta(Dst1, Src1, Typ1, hs);
      send_payload(10, 8'h01);
    join
    wait_end(1);
    rand_mode = 1'b0;
    e = frame_errs(0, 10, 8'h01, 60, Dst1, Src1, Typ1);
    n_cmp++; if (to_flag !== 1'b0) begin n_bad++; $display("FAIL t4_timeout got %b want 0", to_flag); end
    n_cmp++; if (q.size() !== 60) begin n_bad++; $display("FAIL t4_len got %0d want 60", q.size()); end
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL t4_bytes bad=%0d want 0", e); end
    n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL t4_stable got %0d want 0", stab_err); end
    n_cmp++; if (stall_cnt == 0) begin n_bad++; $display("FAIL t4_stalls got 0 want >0"); end
    n_cmp++; if (fs_cnt !== 1 || hd_cnt !== 1 || fe_cnt !== 1) begin
      n_bad++; $display("FAIL t4_pulses got %0d/%0d/%0d want 1/1/1", fs_cnt, hd_cnt, fe_cnt);
    end
    n_cmp++; if (frames_sent !== 32'd3) begin n_bad++; $display("FAIL t4_frames got %0d want 3", frames_sent); end
  endtask

  task automatic test_back_to_back();
    int hs1, hs2, e1, e2;
    logic early = 1'b0;
    do_reset();
    clear_mon();
    hs2 = -1;
    fork
      begin
        send_meta(Dst1, Src1, Typ1, hs1);
        send_payload(10, 8'h01);
      end
      begin
        for (int k = 0; k < 300 && q.size() < 16; k++) @(negedge clk);
        meta_dst = Dst2; meta_src = Src2; meta_type = Typ2; meta_valid = 1'b1;
        for (int k = 0; k < 300 && hs2 < 0; k++) begin
          @(negedge clk);
          if (meta_ready) begin
            if (fe_cnt == 0) early = 1'b1;
            hs2 = cyc;
          end
        end
        if (hs2 < 0) to_flag = 1'b1;
        @(posedge clk);
        #1 meta_valid = 1'b0;
        send_payload(50, 8'h40);
      end
    join
    wait_end(2);
    e1 = frame_errs(0, 10, 8'h01, 60, Dst1, Src1, Typ1);
    e2 = frame_errs(60, 50, 8'h40, 60, Dst2, Src2, Typ2);
    n_cmp++; if (to_flag !== 1'b0) begin n_bad++; $display("FAIL t5_timeout got %b want 0", to_flag); end
    n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL t5_meta_ready_early got %b want 0", early); end
    n_cmp++; if (fs_cyc !== hs2 + 1) begin n_bad++; $display("FAIL t5_hdr_latency got %0d want %0d", fs_cyc, hs2 + 1); end
    n_cmp++; if (q.size() !== 124) begin n_bad++; $display("FAIL t5_len got %0d want 124", q.size()); end
    n_cmp++; if (e1 !== 0 || e2 !== 0) begin n_bad++; $display("FAIL t5_bytes bad=%0d/%0d want 0/0", e1, e2); end
    n_cmp++; if (frames_sent !== 32'd2) begin n_bad++; $display("FAIL t5_frames got %0d want 2", frames_sent); end
  endtask

  task automatic test_reset_mid_frame();
    int hs, e;
    clear_mon();
    send_meta(Dst1, Src1, Typ1, hs);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL t6_tvalid got %b want 0", m_tvalid); end
    n_cmp++; if (meta_ready !== 1'b1) begin n_bad++; $display("FAIL t6_idle got %b want 1", meta_ready); end
    n_cmp++; if (frames_sent !== 32'd0) begin n_bad++; $display("FAIL t6_frames got %0d want 0", frames_sent); end
    n_cmp++; if (q.size() !== 6) begin n_bad++; $display("FAIL t6_partial_len got %0d want 6", q.size()); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    fork
      send_meta(Dst1, Src1, Typ1, hs);
      send_payload(46, 8'h01);
    join
    wait_end(1);
    e = frame_errs(0, 46, 8'h01, 60, Dst1, Src1, Typ1);
    n_cmp++; if (to_flag !== 1'b0) begin n_bad++; $display("FAIL t6_timeout got %b want 0", to_flag); end
    n_cmp++; if (q.size() !== 60 || e !== 0) begin
      n_bad++; $display("FAIL t6_frame len=%0d bad=%0d want 60/0", q.size(), e);
    end
    n_cmp++; if (frames_sent !== 32'd1) begin n_bad++; $display("FAIL t6_frames_after got %0d want 1", frames_sent); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_pad();
    test_no_pad();
    test_random_ready();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
